clock_step_controller: RTL
==========================

// Module: clock_step_controller
// PURPOSE
//  Sequences the CPU clock-enable for the lab board. Runs in one of two
//  modes, selected by a slide switch:
//   - free-running: one tick per RUN_DIV cycles of clock50MHZ.
//   - single-step: one tick per debounced push-button press.
//  A halt request from the CPU freezes ticking. Sits between the board
//  I/O and the processor core; tick is a 1-cycle enable, not a derived clock.
// PARAMETERS
//  RUN_DIV   50_000_000  cycles per tick in RUN (>=2); 1 Hz at 50 MHz
//  DEBOUNCE  500_000     consecutive stable cycles to accept a button change (>=2)
//  DIV_W     26          divider width; must hold RUN_DIV-1
//  DB_W      19          debounce counter width; must hold DEBOUNCE-1
// PORTS
//  clock50MHZ  in   1   board clock, all logic on posedge
//  reset       in   1   synchronous, active-high
//  run_sw      in   1   raw slide switch: 1=RUN, 0=STEP
//  step_btn    in   1   raw push-button, active-high, bouncy, async
//  halt        in   1   CPU halt request, synchronous to clock50MHZ
//  tick        out  1   1-cycle enable pulse to CPU
//  mode        out  2   current state: 00=STEP 01=RUN 10=HALTED
//  tick_count  out  16  ticks issued since reset, wraps
// BEHAVIOUR
//  Reset: state=STEP, tick=0, mode=00, tick_count=0, divider=0,
//   debouncer counter=0, debounced level=0, sync flops=0.
//   Reset mid-operation aborts everything on that edge.
//  Input conditioning:
//   - run_sw: 2-FF synchronised -> run_s; not debounced.
//   - step_btn: 2-FF synchronised, then debounced. The debounced level
//     changes only after DEBOUNCE consecutive cycles where the synced value
//     differs from it; any agreeing cycle clears the count.
//   - A 0->1 debounced transition makes press=1 for exactly one cycle.
//   - A button held through reset counts as a fresh press.
//  State transitions (registered):
//   - STEP/RUN -> HALTED when halt=1; halt has priority over everything.
//   - STEP -> RUN when run_s=1. RUN -> STEP when run_s=0.
//   - HALTED -> STEP on press while run_s=0. No tick for that press.
//     halt is ignored while in HALTED.
//  Divider:
//   - Counts only in RUN. Cleared on entry to and exit from RUN.
//   - In RUN, tick=1 in the cycle after divider==RUN_DIV-1; divider then
//     wraps to 0. Period is exactly RUN_DIV cycles.
//   - First tick comes RUN_DIV cycles after mode becomes 01.
//  Tick rules:
//   - tick is registered and decided from the current state.
//   - STEP: press -> tick=1 on the next cycle.
//   - Latency from the first step_btn sample high to tick is exactly
//     DEBOUNCE+3 cycles.
//   - Never more than one tick per press.
//   - halt=1 in the same cycle as a pending tick suppresses that tick.
//  tick_count: +1 on each tick cycle, mod 2^16 (0xFFFF -> 0x0000).
// STRUCTURE
//  Shared package clock_ctrl_pkg: state encodings ST_STEP/ST_RUN/ST_HALTED
//   (2-bit) and default RUN_DIV/DEBOUNCE constants, reused by the
//   top-level and the bench.
//  Sub-module button_debouncer: synchroniser + debounce counter +
//   rising-edge pulse; parameter DEBOUNCE; ports clock50MHZ, reset,
//   raw, level, press.
//  The top holds the FSM, divider, tick and tick_count registers.
// TESTING  (sim params: RUN_DIV=5, DEBOUNCE=4)
//  1 Reset: reset=1 for 3 cycles with run_sw=1, step_btn=1, halt=0
//    -> tick=0, mode=00, tick_count=0 throughout.
//  2 Run: run_sw=1 after reset -> mode=01 after sync; ticks exactly
//    5 cycles apart; tick_count reads 1,2,3 after 3 ticks.
//  3 Step: run_sw=0.
//    - step_btn high 10 cycles -> one tick, 7 cycles after rise.
//    - 2-cycle glitches -> no tick.
//  4 Halt: in RUN, halt=1 on the cycle a tick is due -> no tick, mode=10,
//    no further ticks. First press with run_sw=0 -> mode=00, no tick.
//    Second press -> tick.
//  5 Wrap: RUN_DIV=2, run 65536 ticks -> tick_count returns to 0x0000.
//  6 Reset mid-RUN with divider=3 -> divider=0, mode=00. Re-entering RUN
//    gives its first tick 5 cycles after mode=01.

Source files
------------

// File: rtl/clock_ctrl_pkg.sv
// Shared definitions for the CPU clock-step controller: state encodings
// (also the value driven on the mode output) and default timing constants.
package clock_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_STEP   = 2'b00,
        ST_RUN    = 2'b01,
        ST_HALTED = 2'b10
    } state_e;

    // 1 Hz tick from a 50 MHz board clock.
    localparam int RUN_DIV_DEFAULT  = 50_000_000;
    // 10 ms of stable input before a button change is accepted.
    localparam int DEBOUNCE_DEFAULT = 500_000;

endpackage

// File: rtl/clock_step_controller_if.sv
// Board-side signals of the clock-step controller. The master is the board /
// CPU side that drives the switch, button and halt request. The slave is the
// controller, which returns the tick enable and status.
interface clock_step_controller_if;

    logic        run_sw;
    logic        step_btn;
    logic        halt;
    logic        tick;
    logic [1:0]  mode;
    logic [15:0] tick_count;

    modport master (
        output run_sw, step_btn, halt,
        input  tick, mode, tick_count
    );

    modport slave (
        input  run_sw, step_btn, halt,
        output tick, mode, tick_count
    );

endinterface

// File: rtl/button_debouncer.sv
// Push-button conditioning: a 2-FF synchroniser, then a debounce counter, then
// a rising-edge detector. press is a one-cycle pulse that comes one cycle
// after the debounced level rises. The level resets low, so a button held
// through reset is reported as a fresh press.
module button_debouncer
    import clock_ctrl_pkg::*;
#(
    parameter int DEBOUNCE = DEBOUNCE_DEFAULT,
    parameter int DB_W     = 19
) (
    input  logic clock50MHZ,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DEBOUNCE - 1);

    logic            sync1_q;
    logic            sync2_q;
    logic [DB_W-1:0] cnt_q;
    logic            level_q;
    logic            level_prev_q;
    logic            press_q;

    // Synchronise the button, accept the new level after DEBOUNCE disagreeing cycles, and flag each rise.
    always_ff @(posedge clock50MHZ) begin
        if (reset) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            cnt_q        <= '0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            press_q      <= 1'b0;
        end else begin
            // NOTE: every register here uses non-blocking assignment. As a result,
            // sync2_q captures the old sync1_q and the chain acts as two stages.
            sync1_q <= raw;
            sync2_q <= sync1_q;
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                cnt_q   <= '0;
                level_q <= sync2_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
            level_prev_q <= level_q;
            press_q      <= level_q & ~level_prev_q;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/clock_step_controller.sv
// CPU clock-enable sequencer. Runs free (one tick every RUN_DIV cycles) or
// single-steps (one tick per debounced button press). A CPU halt request
// freezes ticking until a step press, made with the switch in STEP, releases it.
// The tick output is a one-cycle enable pulse, not a derived clock.
module clock_step_controller
    import clock_ctrl_pkg::*;
#(
    parameter int RUN_DIV  = RUN_DIV_DEFAULT,
    parameter int DEBOUNCE = DEBOUNCE_DEFAULT,
    parameter int DIV_W    = 26,
    parameter int DB_W     = 19
) (
    input  logic                   clock50MHZ,
    input  logic                   reset,
    clock_step_controller_if.slave bus
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

    logic             run_s1_q;
    logic             run_s_q;
    logic             press;
    logic             btn_level_unused;  // the sequencer only needs the press pulse
    state_e           state_q;
    logic [DIV_W-1:0] div_q;
    logic             div_wrap;
    logic             tick_d;
    logic             tick_q;
    logic [15:0]      tick_count_q;

    button_debouncer #(
        .DEBOUNCE (DEBOUNCE),
        .DB_W     (DB_W)
    ) u_step_db (
        .clock50MHZ (clock50MHZ),
        .reset      (reset),
        .raw        (bus.step_btn),
        .level      (btn_level_unused),
        .press      (press)
    );

    // Two-stage synchroniser for the slide switch (a plain level, not debounced).
    always_ff @(posedge clock50MHZ) begin
        if (reset) begin
            run_s1_q <= 1'b0;
            run_s_q  <= 1'b0;
        end else begin
            run_s1_q <= bus.run_sw;
            run_s_q  <= run_s1_q;
        end
    end

    // A tick is due on a press in STEP, or on divider wrap in RUN.
    // A coincident halt request kills it.
    assign div_wrap = (div_q == DIV_LAST);
    assign tick_d   = ~bus.halt & (((state_q == ST_STEP) & press) |
                                   ((state_q == ST_RUN)  & div_wrap));

    // Mode FSM, run divider, registered tick and tick counter.
    always_ff @(posedge clock50MHZ) begin
        if (reset) begin
            state_q      <= ST_STEP;
            div_q        <= '0;
            tick_q       <= 1'b0;
            tick_count_q <= '0;
        end else begin
            tick_q       <= tick_d;
            tick_count_q <= tick_count_q + 16'(tick_d);
            case (state_q)
                ST_STEP: begin
                    div_q <= '0;
                    if (bus.halt) begin
                        state_q <= ST_HALTED;
                    end else if (run_s_q) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (bus.halt) begin
                        state_q <= ST_HALTED;
                        div_q   <= '0;
                    end else if (!run_s_q) begin
                        state_q <= ST_STEP;
                        div_q   <= '0;
                    end else if (div_wrap) begin
                        div_q <= '0;
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                ST_HALTED: begin
                    // halt is ignored here. Only a step press releases the CPU, and that press issues no tick.
                    div_q <= '0;
                    if (press && !run_s_q) begin
                        state_q <= ST_STEP;
                    end
                end
                default: begin
                    state_q <= ST_STEP;
                    div_q   <= '0;
                end
            endcase
        end
    end

    assign bus.tick       = tick_q;
    assign bus.mode       = state_q;
    assign bus.tick_count = tick_count_q;

endmodule
